// File: rtl/vram_pkg.sv
// vram_pkg: shared constants and arbiter state type for the video-memory write path
package vram_pkg;
  localparam int AW_DEF = 17;
  localparam int DW_DEF = 16;
  localparam int FONT_BIT = 16;
  localparam logic [7:0] COLOR_PAGE = 8'hFF;
  typedef enum logic [1:0] {ARB_IDLE, ARB_CPU, ARB_LDR} arb_state_t;
endpackage

// File: rtl/vram_wr_arb_if.sv
// vram_wr_arb_if: CPU strobe, loader handshake and registered RAM write port bundle
interface vram_wr_arb_if #(
  parameter int AW = vram_pkg::AW_DEF,
  parameter int DW = vram_pkg::DW_DEF
);
  logic hold;
  logic cpu_we;
  logic [AW-1:0] cpu_addr;
  logic cpu_hi;
  logic [7:0] cpu_data;
  logic cpu_ovf;
  logic ld_valid;
  logic ld_ready;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic [1:0] ld_be;
  logic [15:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [1:0] wr_be;
  logic scr_we;
  logic fnt_we;
  logic col_we;
  logic idle;
  modport slave (
    input hold, cpu_we, cpu_addr, cpu_hi, cpu_data, ld_valid, ld_addr, ld_data, ld_be,
    output cpu_ovf, ld_ready, wr_addr, wr_data, wr_be, scr_we, fnt_we, col_we, idle
  );
  modport master (
    output hold, cpu_we, cpu_addr, cpu_hi, cpu_data, ld_valid, ld_addr, ld_data, ld_be,
    input cpu_ovf, ld_ready, wr_addr, wr_data, wr_be, scr_we, fnt_we, col_we, idle
  );
endinterface

// File: rtl/vram_wr_fifo.sv
// vram_wr_fifo: loader request FIFO with wrap-around pointers carrying an extra lap bit
module vram_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 35
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW:0] wptr, rptr;
  assign empty = wptr == rptr;
  assign full = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign dout = mem[rptr[PW-1:0]];
  // pointer advance; a pop on a full FIFO frees the slot only after this edge
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end
  // storage needs no reset; empty pointers hide stale contents
  always_ff @(posedge clk)
    if (push && !full) mem[wptr[PW-1:0]] <= din;
endmodule

// File: rtl/vram_wr_arb.sv
// vram_wr_arb: CPU-first write arbiter with starvation guard and region decode for video RAMs
module vram_wr_arb
  import vram_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_CPU_RUN = 8
) (
  input logic CLK,
  input logic RESET,
  vram_wr_arb_if.slave bus
);
  localparam int FW = AW + DW + 2;
  localparam int RW = $clog2(MAX_CPU_RUN + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(MAX_CPU_RUN);
  arb_state_t state, state_n;
  logic cpu_pend;
  logic [AW-1:0] cpu_addr_r;
  logic [7:0] cpu_data_r;
  logic [1:0] cpu_be_r;
  logic [RW-1:0] run_cnt;
  logic full, empty, grant_cpu, grant_ld, gnt;
  logic [FW-1:0] fifo_dout;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_data;
  logic [1:0] g_be;
  assign bus.ld_ready = !full;
  vram_wr_fifo #(.DEPTH(FIFO_DEPTH), .W(FW)) u_fifo (
    .clk(CLK),
    .rst(RESET),
    .push(bus.ld_valid && !full),
    .pop(grant_ld),
    .din({bus.ld_addr, bus.ld_data, bus.ld_be}),
    .dout(fifo_dout),
    .full(full),
    .empty(empty)
  );
  // grant selection: CPU first unless it has run MAX_CPU_RUN times past a waiting loader
  always_comb begin
    grant_cpu = !bus.hold && cpu_pend && (empty || run_cnt != RUN_MAX);
    grant_ld = !bus.hold && !empty && !grant_cpu;
    gnt = grant_cpu || grant_ld;
    state_n = bus.hold ? state : grant_cpu ? ARB_CPU : grant_ld ? ARB_LDR : ARB_IDLE;
    g_addr = grant_cpu ? cpu_addr_r : fifo_dout[FW-1 -: AW];
    g_data = grant_cpu ? {cpu_data_r, cpu_data_r} : fifo_dout[DW+1:2];
    g_be = grant_cpu ? cpu_be_r : fifo_dout[1:0];
  end
  // arbiter state register
  always_ff @(posedge CLK)
    state <= RESET ? ARB_IDLE : state_n;
  // one-entry CPU buffer; a strobe is only lost when the entry is occupied and not leaving
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cpu_pend <= 1'b0;
      bus.cpu_ovf <= 1'b0;
    end else begin
      if (bus.cpu_we && (!cpu_pend || grant_cpu)) begin
        cpu_addr_r <= bus.cpu_addr;
        cpu_data_r <= bus.cpu_data;
        cpu_be_r <= bus.cpu_hi ? 2'b10 : 2'b01;
      end
      cpu_pend <= bus.cpu_we || (cpu_pend && !grant_cpu);
      if (bus.cpu_we && cpu_pend && !grant_cpu) bus.cpu_ovf <= 1'b1;
    end
  end
  // consecutive CPU grants while the loader waits; frozen during hold
  always_ff @(posedge CLK) begin
    if (RESET || (!bus.hold && (grant_ld || empty))) run_cnt <= '0;
    else if (grant_cpu && run_cnt != RUN_MAX) run_cnt <= run_cnt + 1'b1;
  end
  // registered write port with one-hot region enable qualified by byte enables
  always_ff @(posedge CLK) begin
    if (RESET) begin
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      bus.wr_be <= '0;
      bus.scr_we <= 1'b0;
      bus.fnt_we <= 1'b0;
      bus.col_we <= 1'b0;
      bus.idle <= 1'b1;
    end else begin
      if (gnt) begin
        bus.wr_addr <= g_addr[15:0];
        bus.wr_data <= g_data;
        bus.wr_be <= g_be;
      end
      bus.fnt_we <= gnt && g_be != 2'b00 && g_addr[FONT_BIT];
      bus.col_we <= gnt && g_be != 2'b00 && !g_addr[FONT_BIT] && g_addr[15:8] == COLOR_PAGE;
      bus.scr_we <= gnt && g_be != 2'b00 && !g_addr[FONT_BIT] && g_addr[15:8] != COLOR_PAGE;
      bus.idle <= !cpu_pend && empty && !(bus.scr_we || bus.fnt_we || bus.col_we);
    end
  end
endmodule

// File: tb/tb_vram_wr_arb.sv
// tb_vram_wr_arb: directed scenario checks for the video RAM write arbiter
module tb_vram_wr_arb;
  logic clk = 1'b0;
  logic rst;
  int errors = 0;
  int checks = 0;
  logic [2:0] we;
  logic [2:0] obs [12];
  logic [15:0] dat [12];
  vram_wr_arb_if bus ();
  vram_wr_arb dut (.CLK(clk), .RESET(rst), .bus(bus.slave));
  assign we = {bus.scr_we, bus.fnt_we, bus.col_we};
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks += 7;
    if (we !== 3'b000) begin errors++; $display("FAIL reset_we: got %b expected 000", we); end
    if (bus.wr_addr !== 16'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0000", bus.wr_addr); end
    if (bus.wr_data !== 16'h0) begin errors++; $display("FAIL reset_data: got %h expected 0000", bus.wr_data); end
    if (bus.wr_be !== 2'b00) begin errors++; $display("FAIL reset_be: got %b expected 00", bus.wr_be); end
    if (bus.cpu_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", bus.cpu_ovf); end
    if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.ld_ready); end
    if (bus.idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b expected 1", bus.idle); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_cpu_write();
    bus.cpu_we = 1'b1; bus.cpu_addr = 17'h00123; bus.cpu_hi = 1'b1; bus.cpu_data = 8'hA5;
    tick();
    bus.cpu_we = 1'b0;
    checks++;
    if (we !== 3'b000) begin errors++; $display("FAIL cpu_early: got %b expected 000", we); end
    tick();
    checks += 4;
    if (we !== 3'b100) begin errors++; $display("FAIL cpu_we: got %b expected 100", we); end
    if (bus.wr_addr !== 16'h0123) begin errors++; $display("FAIL cpu_addr: got %h expected 0123", bus.wr_addr); end
    if (bus.wr_data !== 16'hA5A5) begin errors++; $display("FAIL cpu_data: got %h expected a5a5", bus.wr_data); end
    if (bus.wr_be !== 2'b10) begin errors++; $display("FAIL cpu_be: got %b expected 10", bus.wr_be); end
    tick();
    checks++;
    if (we !== 3'b000) begin errors++; $display("FAIL cpu_pulse: got %b expected 000", we); end
    tick();
    checks++;
    if (bus.idle !== 1'b1) begin errors++; $display("FAIL cpu_idle: got %b expected 1", bus.idle); end
  endtask

  task automatic test_region();
    logic [16:0] a [4];
    logic [1:0] b [4];
    logic [2:0] ex [6];
    a = '{17'h10040, 17'h0FF10, 17'h00010, 17'h00020};
    b = '{2'b11, 2'b11, 2'b11, 2'b00};
    ex = '{3'b000, 3'b010, 3'b001, 3'b100, 3'b000, 3'b000};
    for (int i = 0; i < 6; i++) begin
      bus.ld_valid = i < 4;
      bus.ld_addr = a[i % 4];
      bus.ld_data = 16'h1111 * 16'(i + 1);
      bus.ld_be = b[i % 4];
      tick();
      obs[i] = we;
      dat[i] = bus.wr_data;
      if (i == 1) begin
        checks++;
        if (bus.wr_addr !== 16'h0040) begin errors++; $display("FAIL region_addr: got %h expected 0040", bus.wr_addr); end
      end
      if (i == 4) begin
        checks++;
        if (bus.wr_be !== 2'b00) begin errors++; $display("FAIL region_be0: got %b expected 00", bus.wr_be); end
      end
    end
    bus.ld_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (obs[i] !== ex[i]) begin errors++; $display("FAIL region_we[%0d]: got %b expected %b", i, obs[i], ex[i]); end
    end
    checks++;
    if (dat[4] !== 16'h4444) begin errors++; $display("FAIL region_data0: got %h expected 4444", dat[4]); end
    tick();
  endtask

  task automatic test_fifo_full();
    bus.hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_addr = 17'h00100 + 17'(i);
      bus.ld_data = 16'hD000 + 16'(i);
      bus.ld_be = 2'b11;
      tick();
      if (i >= 3) begin
        checks++;
        if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL full_ready[%0d]: got %b expected 0", i, bus.ld_ready); end
      end
    end
    bus.ld_valid = 1'b0;
    bus.hold = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      obs[i] = we;
      dat[i] = bus.wr_data;
      if (i == 0) begin
        checks++;
        if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL full_ready_back: got %b expected 1", bus.ld_ready); end
      end
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs[i] !== (i < 4 ? 3'b100 : 3'b000)) begin errors++; $display("FAIL full_we[%0d]: got %b", i, obs[i]); end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dat[i] !== 16'hD000 + 16'(i)) begin errors++; $display("FAIL full_data[%0d]: got %h expected %h", i, dat[i], 16'hD000 + 16'(i)); end
    end
  endtask

  task automatic test_starvation();
    bus.hold = 1'b1;
    bus.ld_valid = 1'b1; bus.ld_addr = 17'h10000; bus.ld_data = 16'hBEEF; bus.ld_be = 2'b11;
    bus.cpu_we = 1'b1; bus.cpu_addr = 17'h00300; bus.cpu_hi = 1'b0; bus.cpu_data = 8'h10;
    tick();
    bus.ld_valid = 1'b0;
    bus.hold = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      bus.cpu_we = k <= 8;
      bus.cpu_data = 8'h10 + 8'(k);
      tick();
      obs[k] = we;
      dat[k] = bus.wr_data;
    end
    bus.cpu_we = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      checks++;
      if (obs[k] !== (k <= 8 || k == 10 ? 3'b100 : k == 9 ? 3'b010 : 3'b000)) begin
        errors++; $display("FAIL starve_we[%0d]: got %b", k, obs[k]);
      end
    end
    checks += 4;
    if (dat[1] !== 16'h1010) begin errors++; $display("FAIL starve_first: got %h expected 1010", dat[1]); end
    if (dat[9] !== 16'hBEEF) begin errors++; $display("FAIL starve_ldr: got %h expected beef", dat[9]); end
    if (dat[10] !== 16'h1818) begin errors++; $display("FAIL starve_resume: got %h expected 1818", dat[10]); end
    if (bus.cpu_ovf !== 1'b0) begin errors++; $display("FAIL starve_ovf: got %b expected 0", bus.cpu_ovf); end
  endtask

  task automatic test_overflow();
    bus.hold = 1'b1;
    bus.cpu_we = 1'b1; bus.cpu_addr = 17'h00200; bus.cpu_hi = 1'b0; bus.cpu_data = 8'h55;
    tick();
    bus.cpu_data = 8'h66;
    tick();
    bus.cpu_we = 1'b0;
    bus.hold = 1'b0;
    checks++;
    if (bus.cpu_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", bus.cpu_ovf); end
    tick();
    checks += 3;
    if (we !== 3'b100) begin errors++; $display("FAIL ovf_we: got %b expected 100", we); end
    if (bus.wr_data !== 16'h5555) begin errors++; $display("FAIL ovf_data: got %h expected 5555", bus.wr_data); end
    if (bus.wr_be !== 2'b01) begin errors++; $display("FAIL ovf_be: got %b expected 01", bus.wr_be); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (we !== 3'b000) begin errors++; $display("FAIL ovf_single[%0d]: got %b expected 000", i, we); end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.cpu_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", bus.cpu_ovf); end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_addr = 17'h00400 + 17'(i);
      bus.ld_data = 16'hC000 + 16'(i);
      bus.ld_be = 2'b11;
      tick();
    end
    bus.ld_valid = 1'b0;
    bus.hold = 1'b0;
    tick();
    checks++;
    if (we !== 3'b100) begin errors++; $display("FAIL mid_active: got %b expected 100", we); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks += 3;
    if (we !== 3'b000) begin errors++; $display("FAIL mid_we: got %b expected 000", we); end
    if (bus.idle !== 1'b1) begin errors++; $display("FAIL mid_idle: got %b expected 1", bus.idle); end
    if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b expected 1", bus.ld_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks += 2;
      if (we !== 3'b000) begin errors++; $display("FAIL mid_after[%0d]: got %b expected 000", i, we); end
      if (bus.idle !== 1'b1) begin errors++; $display("FAIL mid_idle_after[%0d]: got %b expected 1", i, bus.idle); end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.hold = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_hi = 1'b0; bus.cpu_data = '0;
    bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0; bus.ld_be = '0;
    tick();
    tick();
    test_reset();
    test_cpu_write();
    test_region();
    test_fifo_full();
    test_starvation();
    test_overflow();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
